cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
Shares one common data bus (CDB) between result producers (ALU, LSB, future MUL/DIV unit) in the out-of-order RV32I core. Each producer deposits a result, a {value, ROB tag} pair, into a private one-entry holding slot. The block grants one slot per cycle, round-robin, and broadcasts the winner on a registered CDB that feeds RS, LSB and ROB. Rollback flushes all in-flight results.

Parameters:
N_REQ, 3, number of producers; index 0 = ALU, 1 = LSB, 2 = MUL.
TAG_W, 4, ROB tag width; must match ROB depth.
DATA_W, 32, result width.

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
rdy  in  1  global ready; when low the block freezes
rollback  in  1  misprediction flush from ROB
req_valid  in  N_REQ  producer i offers a result
req_ready  out  N_REQ  slot i can accept this cycle
req_data  in  N_REQ*DATA_W  packed results; slice i = [i*DATA_W +: DATA_W]
req_tag  in  N_REQ*TAG_W  packed ROB tags
cdb_valid  out  1  broadcast valid (registered)
cdb_result  out  DATA_W  broadcast value (registered)
cdb_tag  out  TAG_W  broadcast ROB tag (registered)
cdb_src  out  $clog2(N_REQ)  index of the granted producer (registered)

Behaviour:
- Reset (async, rst=1): all slot_full=0; rr_ptr=0; cdb_valid=0; cdb_result=0; cdb_tag=0; cdb_src=0. req_ready reads 0 while rst is high.
- Per slot i: state full/empty plus data and tag registers.
- req_ready[i] = rdy & ~rollback & (~slot_full[i] | grant[i]). It is combinational from state and arbitration only, never from req_valid.
- Capture: on the edge where req_valid[i] & req_ready[i] is true, load the slot and set it full.
- Arbitration is combinational over slot_full only; new requests in the same cycle are not eligible.
  - Scan indices rr_ptr, rr_ptr+1, … mod N_REQ. The first full slot is granted (grant one-hot).
  - After a grant to index g, rr_ptr <= (g+1) mod N_REQ. With no grant, rr_ptr is unchanged.
- Broadcast at the edge:
  - With a grant: cdb_valid<=1, cdb_result<=slot_data[g], cdb_tag<=slot_tag[g], cdb_src<=g, slot g clears unless refilled by the same edge.
  - Without a grant: cdb_valid<=0 and the data/tag/src registers hold.
- Latency: a request accepted in cycle c is visible on the CDB in cycle c+2 at the earliest. Throughput is 1 result/cycle in aggregate and 1 result/cycle per producer when that producer alone is active (simultaneous grant and refill).
- Full: a producer whose slot is full and not granted sees req_ready=0 and must hold valid/data/tag stable (valid/ready handshake).
- Rollback (rdy=1):
  - All slots clear, rr_ptr holds, cdb_valid<=0 at the edge.
  - Same-cycle requests are not captured (req_ready=0).
  - The current CDB output still shows the previous cycle's broadcast; consumers apply rollback priority themselves.
- rdy=0: no state changes, req_ready=0, outputs hold their values (cdb_valid is not re-pulsed when rdy returns). Rollback is ignored while rdy=0.
- Reset mid-operation discards all slots immediately.
- No starvation: any full slot is granted within N_REQ cycles of rdy=1 without rollback.

Optional Feature:
Macro CDB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins; rr_ptr is removed. This lets the ALU always win, which reduces branch-resolution latency.
- Undefined (default): round-robin as specified above.
- All other behaviour is identical in both modes.

Decomposition:
- Shared package cpu_pkg:
  - ROB_TAG_W and DATA_W constants.
  - Producer index constants SRC_ALU=0, SRC_LSB=1, SRC_MUL=2.
  - cdb_pkt_t struct {result, tag}.
- One sub-module, rr_arbiter: N-way one-hot grant from a request vector and a pointer, with the fixed-priority variant under CDB_FIXED_PRIO_EN. The slot logic and output registers stay in cdb_arbiter.

Test Plan:
- Single producer: ALU offers {0x0000_0005, tag 3} in cycle 1 → cdb_valid=1, result 5, tag 3, src 0 in cycle 3. In the following cycle cdb_valid=0.
- Contention: all three producers offer tags 1, 2, 3 in cycle 1 after reset → broadcast order in cycles 3/4/5 is src 0, 1, 2. Under CDB_FIXED_PRIO_EN, a held ALU stream keeps src=0 and LSB is starved.
- Backpressure: ALU streams tags 0..7 on consecutive cycles alone → req_ready stays 1, 8 back-to-back broadcasts. With LSB also full, ALU req_ready drops every other cycle and the two sources alternate.
- Rollback: fill slots 1 and 2, assert rollback for one cycle with ALU also offering → none of the three results appears. cdb_valid=0 the next cycle and all req_ready=1 afterwards.
- rdy freeze: slot 0 full, hold rdy=0 for 5 cycles → no broadcast, req_ready=0, outputs stable. Broadcast occurs on the first edge after rdy=1.
- Async reset: assert rst mid-cycle while slots are full and cdb_valid=1 → cdb_valid=0 immediately with no clock edge. After release, no stale result is broadcast.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared core constants and the CDB packet type used by every result producer/consumer.
package cpu_pkg;

  localparam int ROB_TAG_W = 4;
  localparam int DATA_W    = 32;
  localparam int N_SRC     = 3;

  localparam int SRC_ALU = 0;
  localparam int SRC_LSB = 1;
  localparam int SRC_MUL = 2;

  typedef struct packed {
    logic [DATA_W-1:0]    result;
    logic [ROB_TAG_W-1:0] tag;
  } cdb_pkt_t;

  // Modulo-n increment for small index pointers.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// N-way one-hot arbiter: round-robin from ptr_i by default,
// fixed lowest-index-wins priority when CDB_FIXED_PRIO_EN is defined.
module rr_arbiter #(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
`ifndef CDB_FIXED_PRIO_EN
  input  logic [IDX_W-1:0] ptr_i,
`endif
  input  logic [N-1:0]     req_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] grant_idx_o,
  output logic             grant_any_o
);

  always_comb begin
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] idx;
    logic             found;
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    grant_o     = '0;
    grant_idx_o = '0;
    grant_any_o = 1'b0;
    found       = 1'b0;
    sum         = '0;
    idx         = '0;
    for (int k = 0; k < N; k++) begin
`ifdef CDB_FIXED_PRIO_EN
      sum = (IDX_W+1)'(k);
`else
      sum = {1'b0, ptr_i} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(N)) sum = sum - (IDX_W+1)'(N);
`endif
      idx = sum[IDX_W-1:0];
      if (!found && req_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        grant_idx_o  = idx;
      end
    end
    grant_any_o = found;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one-entry holding slot per producer, one registered broadcast per cycle.
// Build option CDB_FIXED_PRIO_EN replaces round-robin with fixed lowest-index priority.
module cdb_arbiter #(
  parameter int N_REQ  = cpu_pkg::N_SRC,
  parameter int TAG_W  = cpu_pkg::ROB_TAG_W,
  parameter int DATA_W = cpu_pkg::DATA_W,
  localparam int SRC_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    rollback,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ*TAG_W-1:0]  req_tag,
  output logic                    cdb_valid,
  output logic [DATA_W-1:0]       cdb_result,
  output logic [TAG_W-1:0]        cdb_tag,
  output logic [SRC_W-1:0]        cdb_src
);

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [TAG_W-1:0]  tag;
  } slot_t;

  slot_t              slot_q [N_REQ];
  logic [N_REQ-1:0]   full_q, full_d;
  logic               cdb_valid_q, cdb_valid_d;
  logic [DATA_W-1:0]  cdb_result_q, cdb_result_d;
  logic [TAG_W-1:0]   cdb_tag_q, cdb_tag_d;
  logic [SRC_W-1:0]   cdb_src_q, cdb_src_d;

  logic [N_REQ-1:0]   grant;
  logic [N_REQ-1:0]   accept;
  logic [SRC_W-1:0]   grant_idx;
  logic               grant_any;
  logic               active;

`ifndef CDB_FIXED_PRIO_EN
  logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;
`endif

  // Arbitration sees only slots already full; same-cycle requests wait one cycle.
  rr_arbiter #(
    .N     (N_REQ),
    .IDX_W (SRC_W)
  ) u_arb (
`ifndef CDB_FIXED_PRIO_EN
    .ptr_i       (rr_ptr_q),
`endif
    .req_i       (full_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .grant_any_o (grant_any)
  );

  assign active    = rdy & ~rollback;
  // A granted slot empties at this edge, so it can be refilled in the same cycle.
  assign req_ready = rst ? '0 : ({N_REQ{active}} & (~full_q | grant));
  assign accept    = req_valid & req_ready;

  always_comb begin
    full_d       = full_q;
    cdb_valid_d  = cdb_valid_q;
    cdb_result_d = cdb_result_q;
    cdb_tag_d    = cdb_tag_q;
    cdb_src_d    = cdb_src_q;
`ifndef CDB_FIXED_PRIO_EN
    rr_ptr_d     = rr_ptr_q;
`endif
    if (rdy) begin
      if (rollback) begin
        full_d      = '0;
        cdb_valid_d = 1'b0;
      end else begin
        full_d      = (full_q & ~grant) | accept;
        cdb_valid_d = grant_any;
        if (grant_any) begin
          cdb_result_d = slot_q[grant_idx].result;
          cdb_tag_d    = slot_q[grant_idx].tag;
          cdb_src_d    = grant_idx;
`ifndef CDB_FIXED_PRIO_EN
          rr_ptr_d     = SRC_W'(cpu_pkg::wrap_inc(int'(grant_idx), N_REQ));
`endif
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q       <= '0;
      cdb_valid_q  <= 1'b0;
      cdb_result_q <= '0;
      cdb_tag_q    <= '0;
      cdb_src_q    <= '0;
`ifndef CDB_FIXED_PRIO_EN
      rr_ptr_q     <= '0;
`endif
    end else begin
      full_q       <= full_d;
      cdb_valid_q  <= cdb_valid_d;
      cdb_result_q <= cdb_result_d;
      cdb_tag_q    <= cdb_tag_d;
      cdb_src_q    <= cdb_src_d;
`ifndef CDB_FIXED_PRIO_EN
      rr_ptr_q     <= rr_ptr_d;
`endif
    end
  end

  // NOTE: slot payload has no reset; it is only read while full_q says it holds a captured value.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (accept[i]) begin
        slot_q[i] <= '{result: req_data[i*DATA_W +: DATA_W], tag: req_tag[i*TAG_W +: TAG_W]};
      end
    end
  end

  assign cdb_valid  = cdb_valid_q;
  assign cdb_result = cdb_result_q;
  assign cdb_tag    = cdb_tag_q;
  assign cdb_src    = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus randomized traffic
// compared against a cycle-level reference model of the slot/grant rules.
module tb_cdb_arbiter;
  import cpu_pkg::*;

  localparam int N  = 3;
  localparam int DW = 32;
  localparam int TW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            rdy;
  logic            rollback;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*DW-1:0] req_data;
  logic [N*TW-1:0] req_tag;
  logic            cdb_valid;
  logic [DW-1:0]   cdb_result;
  logic [TW-1:0]   cdb_tag;
  logic [1:0]      cdb_src;

  cdb_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .rollback   (rollback),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .req_tag    (req_tag),
    .cdb_valid  (cdb_valid),
    .cdb_result (cdb_result),
    .cdb_tag    (cdb_tag),
    .cdb_src    (cdb_src)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Producer-side offers
  logic          v [N];
  logic [DW-1:0] d [N];
  logic [TW-1:0] t [N];

  // Reference model state
  bit            m_full [N];
  logic [DW-1:0] m_data [N];
  logic [TW-1:0] m_tag  [N];
  int            m_ptr;
  logic          m_cv;
  logic [DW-1:0] m_res;
  logic [TW-1:0] m_ctag;
  int            m_src;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int m_winner();
    for (int k = 0; k < N; k++) begin
`ifdef CDB_FIXED_PRIO_EN
      int idx = k;
`else
      int idx = (m_ptr + k) % N;
`endif
      if (m_full[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_full[i] = 1'b0;
    m_ptr  = 0;
    m_cv   = 1'b0;
    m_res  = '0;
    m_ctag = '0;
    m_src  = 0;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]           = v[i];
      req_data[i*DW +: DW]   = d[i];
      req_tag[i*TW +: TW]    = t[i];
    end
  endtask

  // One clock cycle: called at a falling edge with offers set, returns at the next falling edge.
  task automatic tick();
    logic [N-1:0] rdy_exp;
    logic [N-1:0] acc;
    int w;
    drive();
    #1;
    w = m_winner();
    for (int i = 0; i < N; i++)
      rdy_exp[i] = rdy & ~rollback & (!m_full[i] || (w == i));
    check("req_ready", 64'(req_ready), 64'(rdy_exp));
    for (int i = 0; i < N; i++) acc[i] = rdy_exp[i] & v[i];
    @(posedge clk);
    if (rdy) begin
      if (rollback) begin
        for (int i = 0; i < N; i++) m_full[i] = 1'b0;
        m_cv = 1'b0;
      end else begin
        if (w >= 0) begin
          m_cv      = 1'b1;
          m_res     = m_data[w];
          m_ctag    = m_tag[w];
          m_src     = w;
          m_full[w] = 1'b0;
          m_ptr     = (w + 1) % N;
        end else begin
          m_cv = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
          if (acc[i]) begin
            m_full[i] = 1'b1;
            m_data[i] = d[i];
            m_tag[i]  = t[i];
          end
        end
      end
    end
    #1;
    check("cdb_valid", 64'(cdb_valid), 64'(m_cv));
    check("cdb_result", 64'(cdb_result), 64'(m_res));
    check("cdb_tag", 64'(cdb_tag), 64'(m_ctag));
    check("cdb_src", 64'(cdb_src), 64'(m_src));
    for (int i = 0; i < N; i++) if (acc[i]) v[i] = 1'b0;
    @(negedge clk);
  endtask

  task automatic clear_offers();
    for (int i = 0; i < N; i++) begin
      v[i] = 1'b0;
      d[i] = '0;
      t[i] = '0;
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    rdy      = 1'b1;
    rollback = 1'b0;
    clear_offers();
    drive();
    #1;
    check("rst_cdb_valid", 64'(cdb_valid), 64'd0);
    check("rst_cdb_result", 64'(cdb_result), 64'd0);
    check("rst_cdb_tag", 64'(cdb_tag), 64'd0);
    check("rst_cdb_src", 64'(cdb_src), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    rdy = 1'b1;
    rollback = 1'b0;
    clear_offers();
    drive();
    @(negedge clk);
    do_reset();

    // Single ALU result: visible two cycles after the offer, then gone
    v[SRC_ALU] = 1'b1; d[SRC_ALU] = 32'h0000_0005; t[SRC_ALU] = 4'd3;
    tick();
    tick();
    check("single_valid", 64'(cdb_valid), 64'd1);
    check("single_result", 64'(cdb_result), 64'd5);
    check("single_tag", 64'(cdb_tag), 64'd3);
    check("single_src", 64'(cdb_src), 64'd0);
    tick();
    check("single_after", 64'(cdb_valid), 64'd0);

    // Contention: all three at once, drained in index order
    do_reset();
    for (int i = 0; i < N; i++) begin
      v[i] = 1'b1; d[i] = 32'h100 + 32'(i); t[i] = 4'(i + 1);
    end
    tick();
    tick();
    check("cont_src0", 64'(cdb_src), 64'd0);
    check("cont_tag0", 64'(cdb_tag), 64'd1);
    tick();
    check("cont_src1", 64'(cdb_src), 64'd1);
    check("cont_tag1", 64'(cdb_tag), 64'd2);
    tick();
    check("cont_src2", 64'(cdb_src), 64'd2);
    check("cont_tag2", 64'(cdb_tag), 64'd3);
    tick();

    // ALU alone streams tags 0..7 back to back
    do_reset();
    for (int k = 0; k < 8; k++) begin
      v[SRC_ALU] = 1'b1; d[SRC_ALU] = 32'hA000 + 32'(k); t[SRC_ALU] = 4'(k);
      tick();
      check("stream_ready", 64'(v[SRC_ALU]), 64'd0);
    end
    tick();
    tick();

    // ALU and LSB both streaming
    do_reset();
    for (int k = 0; k < 12; k++) begin
      if (!v[SRC_ALU]) begin v[SRC_ALU] = 1'b1; d[SRC_ALU] = $urandom; t[SRC_ALU] = 4'($urandom_range(0, 15)); end
      if (!v[SRC_LSB]) begin v[SRC_LSB] = 1'b1; d[SRC_LSB] = $urandom; t[SRC_LSB] = 4'($urandom_range(0, 15)); end
      tick();
    end
    clear_offers();
    for (int k = 0; k < 4; k++) tick();

    // Rollback flushes slots 1 and 2 and blocks the ALU offer
    do_reset();
    v[SRC_LSB] = 1'b1; d[SRC_LSB] = 32'h1111; t[SRC_LSB] = 4'd7;
    v[SRC_MUL] = 1'b1; d[SRC_MUL] = 32'h2222; t[SRC_MUL] = 4'd8;
    tick();
    rollback = 1'b1;
    v[SRC_ALU] = 1'b1; d[SRC_ALU] = 32'h3333; t[SRC_ALU] = 4'd9;
    tick();
    check("rb_valid", 64'(cdb_valid), 64'd0);
    rollback = 1'b0;
    clear_offers();
    tick();
    check("rb_ready_after", 64'(req_ready), 64'h7);
    check("rb_no_result", 64'(cdb_valid), 64'd0);
    tick();

    // rdy freeze with slot 0 full
    do_reset();
    v[SRC_ALU] = 1'b1; d[SRC_ALU] = 32'hBEEF; t[SRC_ALU] = 4'd5;
    tick();
    rdy = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    rdy = 1'b1;
    tick();
    check("freeze_release_valid", 64'(cdb_valid), 64'd1);
    check("freeze_release_result", 64'(cdb_result), 64'hBEEF);
    tick();

    // Randomized traffic with occasional stalls and rollbacks
    do_reset();
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!v[i] && $urandom_range(0, 9) < 6) begin
          v[i] = 1'b1; d[i] = $urandom; t[i] = 4'($urandom_range(0, 15));
        end
      end
      rdy      = ($urandom_range(0, 9) != 0);
      rollback = ($urandom_range(0, 19) == 0);
      tick();
    end
    rdy = 1'b1;
    rollback = 1'b0;

    // Asynchronous reset mid-cycle while busy
    do_reset();
    for (int i = 0; i < N; i++) begin
      v[i] = 1'b1; d[i] = 32'hC0 + 32'(i); t[i] = 4'(i + 10);
    end
    tick();
    tick();
    check("areset_pre_valid", 64'(cdb_valid), 64'd1);
    #3;
    rst = 1'b1;
    #1;
    check("areset_valid", 64'(cdb_valid), 64'd0);
    check("areset_ready", 64'(req_ready), 64'd0);
    model_reset();
    clear_offers();
    drive();
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
